// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: advances one of four patterns on each rising edge of a slow tick
// and gates the registered result with a 4-bit PWM brightness control.
module led_pattern_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic [1:0]       mode,
   input  logic             pause,
   input  logic [3:0]       brightness,
   output logic [WIDTH-1:0] LED,
   output logic             step_strobe
);

   typedef enum logic [1:0] {
      ModeRotate = 2'd0,
      ModeBounce = 2'd1,
      ModeCount  = 2'd2,
      ModeToggle = 2'd3
   } mode_e;

   localparam logic [WIDTH-1:0] PatOne = {{(WIDTH-1){1'b0}}, 1'b1};

   logic             tick_prev_q, tick_prev_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic             dir_q, dir_d;
   logic [3:0]       pwm_cnt_q, pwm_cnt_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic             strobe_q, strobe_d;
   logic             rise;
   logic             pwm_en;
   logic [WIDTH-1:0] alt_seed;

   for (genvar g = 0; g < WIDTH; g++) begin : g_alt_seed
      assign alt_seed[g] = (g % 2 == 0);
   end

   always_comb begin
      tick_prev_d = tick_in;
      mode_d      = mode;
      pat_d       = pat_q;
      dir_d       = dir_q;
      strobe_d    = 1'b0;
      rise        = tick_in & ~tick_prev_q;

      if (mode != mode_q) begin
         // Mode change reseeds and swallows any coincident step request.
         dir_d = 1'b0;
         unique case (mode_e'(mode))
            ModeRotate: pat_d = PatOne;
            ModeBounce: pat_d = PatOne;
            ModeCount:  pat_d = '0;
            ModeToggle: pat_d = alt_seed;
         endcase
      end else if (rise && !pause) begin
         strobe_d = 1'b1;
         unique case (mode_e'(mode_q))
            ModeRotate: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            ModeBounce: begin
               if (!dir_q && pat_q[WIDTH-1]) begin
                  dir_d = 1'b1;
                  pat_d = pat_q >> 1;
               end else if (dir_q && pat_q[0]) begin
                  dir_d = 1'b0;
                  pat_d = pat_q << 1;
               end else if (dir_q) begin
                  pat_d = pat_q >> 1;
               end else begin
                  pat_d = pat_q << 1;
               end
            end
            ModeCount:  pat_d = pat_q + PatOne;
            ModeToggle: pat_d = ~pat_q;
         endcase
      end

      pwm_cnt_d = pwm_cnt_q + 4'd1;
      pwm_en    = (brightness == 4'hf) || (pwm_cnt_q < brightness);
      led_d     = pwm_en ? pat_q : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Previous tick starts high so a tick already high at release is not a step.
         tick_prev_q <= 1'b1;
         mode_q      <= 2'd0;
         pat_q       <= PatOne;
         dir_q       <= 1'b0;
         pwm_cnt_q   <= 4'd0;
         led_q       <= '0;
         strobe_q    <= 1'b0;
      end else begin
         tick_prev_q <= tick_prev_d;
         mode_q      <= mode_d;
         pat_q       <= pat_d;
         dir_q       <= dir_d;
         pwm_cnt_q   <= pwm_cnt_d;
         led_q       <= led_d;
         strobe_q    <= strobe_d;
      end
   end

   assign LED         = led_q;
   assign step_strobe = strobe_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Testbench for led_pattern_seq: directed scenarios plus random stimulus against a
// step-count based reference model.
module tb_led_pattern_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick_in = 1'b1;
   logic [1:0]   mode = 2'd0;
   logic         pause = 1'b0;
   logic [3:0]   brightness = 4'hf;
   logic [W-1:0] led;
   logic         step_strobe;

   int total = 0;
   int bad = 0;

   // Reference model: pattern is a pure function of (active mode, steps since seed).
   bit           m_prev_tick;
   logic [1:0]   m_mode_seen;
   logic [1:0]   m_kind;
   int unsigned  m_steps;
   int           m_pwm;
   logic [W-1:0] exp_led;
   logic         exp_strobe;
   int           exp_strobes = 0;
   int           obs_strobes = 0;

   always #10 clk = ~clk;

   led_pattern_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_in    (tick_in),
      .mode       (mode),
      .pause      (pause),
      .brightness (brightness),
      .LED        (led),
      .step_strobe(step_strobe)
   );

   function automatic logic [W-1:0] pat_of(input logic [1:0] kind, input int unsigned k);
      logic [W-1:0] alt;
      logic [W-1:0] one;
      int unsigned  p;
      int unsigned  pos;
      alt = '0;
      for (int i = 0; i < W; i += 2) alt[i] = 1'b1;
      one = 1;
      case (kind)
         2'd0: pat_of = one << (k % W);
         2'd1: begin
            // Position walks 0..W-1..1 with period 2W-2.
            p      = k % (2 * W - 2);
            pos    = (p < W) ? p : (2 * W - 2) - p;
            pat_of = one << pos;
         end
         2'd2: pat_of = k[W-1:0];
         default: pat_of = k[0] ? ~alt : alt;
      endcase
   endfunction

   task automatic model_reset();
      m_prev_tick = 1'b1;
      m_mode_seen = 2'd0;
      m_kind      = 2'd0;
      m_steps     = 0;
      m_pwm       = 0;
      exp_led     = '0;
      exp_strobe  = 1'b0;
   endtask

   task automatic clk_cycle();
      logic [W-1:0] cur;
      logic         rise;
      @(posedge clk);
      if (rst_n) begin
         cur        = pat_of(m_kind, m_steps);
         exp_led    = (brightness == 4'd15 || m_pwm < int'(brightness)) ? cur : '0;
         rise       = tick_in && !m_prev_tick;
         exp_strobe = 1'b0;
         if (mode != m_mode_seen) begin
            m_kind  = mode;
            m_steps = 0;
         end else if (rise && !pause) begin
            m_steps++;
            exp_strobe = 1'b1;
            exp_strobes++;
         end
         m_pwm       = (m_pwm + 1) % 16;
         m_prev_tick = tick_in;
         m_mode_seen = mode;
      end
      #1;
      if (step_strobe === 1'b1) obs_strobes++;
   endtask

   task automatic apply_reset();
      #3 rst_n = 1'b0;
      model_reset();
      repeat (2) clk_cycle();
      rst_n = 1'b1;
   endtask

   task automatic pulse_tick(input int lo, input int hi);
      tick_in = 1'b0;
      repeat (lo) clk_cycle();
      tick_in = 1'b1;
      repeat (hi) clk_cycle();
   endtask

   task automatic test_reset();
      tick_in    = 1'b1;
      mode       = 2'd0;
      brightness = 4'hf;
      apply_reset();
      total++;
      if (led !== 8'h00 || step_strobe !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: LED=%h strobe=%b want LED=00 strobe=0", led, step_strobe);
      end
      obs_strobes = 0;
      exp_strobes = 0;
      repeat (4) clk_cycle();
      total++;
      if (led !== 8'h01 || led !== exp_led) begin
         bad++;
         $display("FAIL reset_release_led: LED=%h want 01 (model %h)", led, exp_led);
      end
      total++;
      if (obs_strobes !== 0 || exp_strobes !== 0) begin
         bad++;
         $display("FAIL reset_no_spurious_step: strobes=%0d want 0", obs_strobes);
      end
      tick_in = 1'b0;
      clk_cycle();
      tick_in = 1'b1;
      clk_cycle();
      total++;
      if (step_strobe !== 1'b1 || led !== 8'h01) begin
         bad++;
         $display("FAIL latency_first_clk: strobe=%b LED=%h want strobe=1 LED=01",
                  step_strobe, led);
      end
      clk_cycle();
      total++;
      if (step_strobe !== 1'b0 || led !== 8'h02 || led !== exp_led) begin
         bad++;
         $display("FAIL latency_second_clk: strobe=%b LED=%h want strobe=0 LED=02",
                  step_strobe, led);
      end
      // Reset lands between a rising tick and the clock that would capture it.
      tick_in = 1'b0;
      clk_cycle();
      tick_in = 1'b1;
      apply_reset();
      total++;
      if (led !== 8'h00) begin
         bad++;
         $display("FAIL reset_async: LED=%h want 00", led);
      end
      obs_strobes = 0;
      repeat (3) clk_cycle();
      total++;
      if (obs_strobes !== 0 || led !== 8'h01) begin
         bad++;
         $display("FAIL reset_mid_step: strobes=%0d LED=%h want 0 and 01", obs_strobes, led);
      end
   endtask

   task automatic test_rotate();
      logic [W-1:0] want;
      int           s0;
      int           e0;
      want = 8'h01;
      for (int i = 0; i < 9; i++) begin
         s0 = obs_strobes;
         e0 = exp_strobes;
         pulse_tick(2, 2);
         want = {want[W-2:0], want[W-1]};
         total++;
         if (led !== exp_led || led !== want) begin
            bad++;
            $display("FAIL rotate_step%0d: LED=%h want %h", i, led, exp_led);
         end
         total++;
         if (obs_strobes - s0 !== 1 || exp_strobes - e0 !== 1) begin
            bad++;
            $display("FAIL rotate_strobe%0d: strobes=%0d want 1", i, obs_strobes - s0);
         end
      end
   endtask

   task automatic test_bounce();
      int n_top = 0;
      int n_bot = 0;
      tick_in = 1'b1;
      mode    = 2'd1;
      apply_reset();
      clk_cycle();
      for (int i = 0; i < 16; i++) begin
         pulse_tick(2, 2);
         if (led === 8'h80) n_top++;
         if (led === 8'h01) n_bot++;
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL bounce_step%0d: LED=%h want %h", i, led, exp_led);
         end
      end
      total++;
      if (n_top !== 1 || n_bot !== 1) begin
         bad++;
         $display("FAIL bounce_ends: top=%0d bottom=%0d want 1 and 1", n_top, n_bot);
      end
   endtask

   task automatic test_count_then_toggle();
      int s0;
      mode = 2'd2;
      repeat (2) clk_cycle();
      for (int i = 0; i < 255; i++) pulse_tick(1, 1);
      clk_cycle();
      total++;
      if (led !== 8'hff || led !== exp_led) begin
         bad++;
         $display("FAIL count_preload: LED=%h want ff (model %h)", led, exp_led);
      end
      pulse_tick(1, 2);
      total++;
      if (led !== 8'h00 || led !== exp_led) begin
         bad++;
         $display("FAIL count_wrap: LED=%h want 00 (model %h)", led, exp_led);
      end
      tick_in = 1'b0;
      clk_cycle();
      s0      = obs_strobes;
      tick_in = 1'b1;
      mode    = 2'd3;
      repeat (2) clk_cycle();
      total++;
      if (led !== 8'h55 || led !== exp_led || obs_strobes !== s0) begin
         bad++;
         $display("FAIL toggle_seed: LED=%h strobes=%0d want 55 and 0", led, obs_strobes - s0);
      end
      pulse_tick(2, 2);
      total++;
      if (led !== 8'haa || led !== exp_led) begin
         bad++;
         $display("FAIL toggle_step: LED=%h want aa (model %h)", led, exp_led);
      end
   endtask

   task automatic test_pause();
      int s0;
      s0    = obs_strobes;
      pause = 1'b1;
      for (int i = 0; i < 3; i++) pulse_tick(2, 2);
      total++;
      if (led !== 8'haa || obs_strobes !== s0 || led !== exp_led) begin
         bad++;
         $display("FAIL pause_hold: LED=%h strobes=%0d want aa and 0", led, obs_strobes - s0);
      end
      pause = 1'b0;
      repeat (3) clk_cycle();
      pulse_tick(2, 2);
      total++;
      if (led !== 8'h55 || obs_strobes - s0 !== 1 || exp_strobes < 1) begin
         bad++;
         $display("FAIL pause_release: LED=%h strobes=%0d want 55 and 1",
                  led, obs_strobes - s0);
      end
   endtask

   task automatic test_pwm();
      int on_cnt;
      brightness = 4'd4;
      repeat (16) clk_cycle();
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         clk_cycle();
         if (led !== 8'h00) on_cnt++;
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL pwm4_cycle%0d: LED=%h want %h", i, led, exp_led);
         end
      end
      total++;
      if (on_cnt !== 4) begin
         bad++;
         $display("FAIL pwm4_duty: on=%0d want 4", on_cnt);
      end
      brightness = 4'd0;
      on_cnt     = 0;
      for (int i = 0; i < 20; i++) begin
         clk_cycle();
         if (led !== 8'h00) on_cnt++;
      end
      total++;
      if (on_cnt !== 0) begin
         bad++;
         $display("FAIL pwm0_off: on=%0d want 0", on_cnt);
      end
      brightness = 4'd15;
      on_cnt     = 0;
      for (int i = 0; i < 20; i++) begin
         clk_cycle();
         if (led === 8'h55) on_cnt++;
      end
      total++;
      if (on_cnt !== 20) begin
         bad++;
         $display("FAIL pwm15_on: cycles_on=%0d want 20", on_cnt);
      end
   endtask

   task automatic test_random();
      mode    = 2'($urandom_range(0, 3));
      tick_in = 1'($urandom_range(0, 1));
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
         if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
         clk_cycle();
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL random_led@%0d: LED=%h want %h", i, led, exp_led);
         end
         total++;
         if (step_strobe !== exp_strobe) begin
            bad++;
            $display("FAIL random_strobe@%0d: strobe=%b want %b", i, step_strobe, exp_strobe);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_rotate();
      test_bounce();
      test_count_then_toggle();
      test_pause();
      test_pwm();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
